// File: rtl/simple_cpu_p.sv
// Multi-cycle 8-register CPU: LOAD/FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
// with a single shared word-addressed memory port and registered bus outputs.
module simple_cpu_p #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] start_pc,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out,
  output logic          halted
);

  typedef enum logic [2:0] {
    ST_LOAD, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_MOVI, OP_MOV, OP_ADD, OP_AND, OP_LDR, OP_STR, OP_BEQZ, OP_HALT
  } op_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] regs_q [8];
  logic [DW-1:0] regs_d [8];
  logic [DW-1:0] out_q, out_d;
  logic          halted_q, halted_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  op_t           op;
  logic [2:0]    rd, rn, rm;
  logic [DW-1:0] imm_sx, rd_val, rn_val, rm_val;
  logic [AW-1:0] ea;
  logic          wr_en;
  logic [DW-1:0] wr_val;

  assign op     = op_t'(ir_q[15:13]);
  assign rd     = ir_q[10:8];
  assign rn     = ir_q[7:5];
  assign rm     = ir_q[2:0];
  assign imm_sx = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
  assign rd_val = regs_q[rd];
  assign rn_val = regs_q[rn];
  assign rm_val = regs_q[rm];
  assign ea     = rn_val[AW-1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    out_d       = out_q;
    halted_d    = halted_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    wr_en       = 1'b0;
    wr_val      = '0;

    case (state_q)
      ST_LOAD: begin
        pc_d    = start_pc;
        state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = mem_rdata[15:0];
        pc_d    = pc_q + AW'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_MOVI: begin wr_en = 1'b1; wr_val = imm_sx; end
          OP_MOV:  begin wr_en = 1'b1; wr_val = rm_val; end
          OP_ADD:  begin wr_en = 1'b1; wr_val = rn_val + rm_val; end
          OP_AND:  begin wr_en = 1'b1; wr_val = rn_val & rm_val; end
          OP_LDR: begin
            state_d    = ST_MEM;
            mem_rd_d   = 1'b1;
            mem_addr_d = ea;
          end
          OP_STR: begin
            state_d     = ST_MEM;
            mem_wr_d    = 1'b1;
            mem_addr_d  = ea;
            mem_wdata_d = rd_val;
          end
          // pc_q already points past this instruction, so 0xFF lands back on it
          OP_BEQZ: if (rd_val == '0) pc_d = pc_q + imm_sx[AW-1:0];
          OP_HALT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM:  state_d = (op == OP_LDR) ? ST_WB : ST_FETCH;
      ST_WB: begin
        wr_en   = 1'b1;
        wr_val  = mem_rdata;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_LOAD;
    endcase

    if (wr_en) begin
      regs_d[rd] = wr_val;
      out_d      = wr_val;
    end

    // Bus strobes are registered, so the fetch request is set up on entry to FETCH
    if (state_d == ST_FETCH) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      pc_q        <= '0;
      ir_q        <= '0;
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      out_q       <= '0;
      halted_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      out_q       <= out_d;
      halted_q    <= halted_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign out       = out_q;
  assign halted    = halted_q;

endmodule
